cpu_ctrl_unit: RTL and testbench

- Sequencing control unit for the CPU core. Fetches 32-bit instruction words from ROM and steps a multi-cycle FSM.
- Drives the core's data-bus mux select, register-file write enables, adder in/out enables and add/sub mode.
- Runs the slave-bus write handshake.
- Sits directly upstream of the register/adder datapath and is the sole source of its control signals.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_instr_decode.sv | 42 ++++
 rtl/cpu_ctrl_unit.sv | 133 +++++++++++++
 tb/tb_cpu_ctrl_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcodes, FSM states, instruction fields.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [4:0] CS_ADDER_OUT = 5'd16;
  localparam logic [4:0] CS_ZERO      = 5'd17;

  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StEx1, StEx2, StWb, StBus, StHalt
  } state_e;

  typedef enum logic [2:0] {
    OpcNop, OpcMov, OpcAdd, OpcSub, OpcStore, OpcJmp, OpcHalt
  } op_class_e;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: splits a 32-bit word into op class and operand fields.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_e   op_class,
  output logic [15:0] rd_oh,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [15:0] imm,
  output logic        illegal
);

  logic [3:0] op;
  logic [3:0] rd;

  always_comb begin
    op       = instr[OP_LSB +: 4];
    rd       = instr[RD_LSB +: 4];
    rs1      = instr[RS1_LSB +: 4];
    rs2      = instr[RS2_LSB +: 4];
    imm      = instr[IMM_LSB +: 16];
    rd_oh    = 16'h0001 << rd;
    illegal  = 1'b0;
    op_class = OpcNop;
    case (op)
      OP_NOP:   op_class = OpcNop;
      OP_MOV:   op_class = OpcMov;
      OP_ADD:   op_class = OpcAdd;
      OP_SUB:   op_class = OpcSub;
      OP_STORE: op_class = OpcStore;
      OP_JMP:   op_class = OpcJmp;
      OP_HALT:  op_class = OpcHalt;
      // Undefined opcodes run as NOP but are flagged.
      default: begin
        op_class = OpcNop;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle sequencing FSM: fetches from ROM and drives all datapath and bus controls.
module cpu_ctrl_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] rom_in,
  output logic [31:0] rom_addr,
  input  logic        slave_ready,
  output logic [4:0]  cs,
  output logic [15:0] reg_en,
  output logic        adder_in_en,
  output logic        adder_out_en,
  output logic        add_sub_mode,
  output logic        addr_en,
  output logic        wdata_en,
  output logic        bus_valid,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [31:0] dec_in;
  op_class_e   dec_class;
  logic [15:0] dec_rd_oh;
  logic [3:0]  dec_rs1;
  logic [3:0]  dec_rs2;
  logic [15:0] dec_imm;
  logic        dec_illegal;

  // In DECODE the fresh ROM word is decoded; every later state works from IR.
  assign dec_in = (state_q == StDecode) ? rom_in : ir_q;

  cpu_instr_decode u_decode (
    .instr    (dec_in),
    .op_class (dec_class),
    .rd_oh    (dec_rd_oh),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    illegal_d    = illegal_q;
    cs           = CS_ZERO;
    reg_en       = '0;
    adder_in_en  = 1'b0;
    adder_out_en = 1'b0;
    add_sub_mode = 1'b1;
    addr_en      = 1'b0;
    wdata_en     = 1'b0;
    bus_valid    = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      StIdle: if (run) state_d = StFetch;
      StFetch: state_d = run ? StDecode : StIdle;
      StDecode: begin
        ir_d = rom_in;
        pc_d = (dec_class == OpcJmp) ? {16'h0000, dec_imm} : pc_q + PC_INC;
        if (dec_illegal) illegal_d = 1'b1;
        case (dec_class)
          OpcMov, OpcAdd, OpcSub, OpcStore: state_d = StEx1;
          OpcHalt:                          state_d = StHalt;
          default:                          state_d = StFetch;
        endcase
      end
      StEx1: begin
        cs      = {1'b0, dec_rs1};
        state_d = StFetch;
        case (dec_class)
          OpcMov:         reg_en = dec_rd_oh;
          OpcAdd, OpcSub: begin adder_in_en = 1'b1; state_d = StEx2; end
          OpcStore:       begin addr_en = 1'b1; state_d = StEx2; end
          default:        ;
        endcase
      end
      StEx2: begin
        cs      = {1'b0, dec_rs2};
        state_d = StFetch;
        case (dec_class)
          OpcAdd, OpcSub: begin
            add_sub_mode = (dec_class == OpcAdd);
            adder_out_en = 1'b1;
            state_d      = StWb;
          end
          OpcStore: begin wdata_en = 1'b1; state_d = StBus; end
          default:  ;
        endcase
      end
      StWb: begin
        cs      = CS_ADDER_OUT;
        reg_en  = dec_rd_oh;
        state_d = StFetch;
      end
      StBus: begin
        bus_valid = 1'b1;
        if (slave_ready) state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign rom_addr = pc_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Directed bench for cpu_ctrl_unit with a 1-cycle-latency ROM model.
module tb_cpu_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] rom_in;
  logic [31:0] rom_addr;
  logic        slave_ready;
  logic [4:0]  cs;
  logic [15:0] reg_en;
  logic        adder_in_en, adder_out_en, add_sub_mode;
  logic        addr_en, wdata_en, bus_valid, halted, illegal;

  logic [31:0] rom [0:63];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_in <= rom[rom_addr[5:0]];

  cpu_ctrl_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .rom_in       (rom_in),
    .rom_addr     (rom_addr),
    .slave_ready  (slave_ready),
    .cs           (cs),
    .reg_en       (reg_en),
    .adder_in_en  (adder_in_en),
    .adder_out_en (adder_out_en),
    .add_sub_mode (add_sub_mode),
    .addr_en      (addr_en),
    .wdata_en     (wdata_en),
    .bus_valid    (bus_valid),
    .halted       (halted),
    .illegal      (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  // Reset, release, and advance into the first FETCH (cycle k=0 of the instruction at pc 0).
  task automatic start();
    rst_n       = 1'b0;
    run         = 1'b1;
    slave_ready = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n       = 1'b0;
    run         = 1'b0;
    slave_ready = 1'b0;
    clear_rom();

    // Reset state
    step(2);
    check_eq("rst_cs", 32'(cs), 32'd17);
    check_eq("rst_reg_en", 32'(reg_en), 32'h0);
    check_eq("rst_enables", {adder_in_en, adder_out_en, addr_en, wdata_en, bus_valid}, 32'h0);
    check_eq("rst_mode", 32'(add_sub_mode), 32'd1);
    check_eq("rst_halted_illegal", {halted, illegal}, 32'h0);
    check_eq("rst_pc", rom_addr, 32'h0);
    step(3);
    check_eq("idle_no_run_pc", rom_addr, 32'h0);

    // NOP stream
    start();
    check_eq("nop_fetch_pc0", rom_addr, 32'h0);
    step(1);
    check_eq("nop_decode_cs", 32'(cs), 32'd17);
    step(1);
    check_eq("nop_fetch_pc1", rom_addr, 32'h1);
    check_eq("nop_reg_en", 32'(reg_en), 32'h0);
    step(2);
    check_eq("nop_fetch_pc2", rom_addr, 32'h2);

    // ADD R3,R1,R2 then MOV R7,R3
    clear_rom();
    rom[0] = 32'h2312_0000;
    rom[1] = 32'h1730_0000;
    start();
    step(2);
    check_eq("add_ex1_cs", 32'(cs), 32'd1);
    check_eq("add_ex1_in_en", 32'(adder_in_en), 32'd1);
    step(1);
    check_eq("add_ex2_cs", 32'(cs), 32'd2);
    check_eq("add_ex2_mode_out", {add_sub_mode, adder_out_en, adder_in_en}, 32'b110);
    step(1);
    check_eq("add_wb_cs", 32'(cs), 32'd16);
    check_eq("add_wb_reg_en", 32'(reg_en), 32'h0008);
    step(1);
    check_eq("add_next_fetch", {reg_en, 11'h0, cs}, {16'h0, 11'h0, 5'd17});
    step(2);
    check_eq("mov_ex1_cs", 32'(cs), 32'd3);
    check_eq("mov_ex1_reg_en", 32'(reg_en), 32'h0080);
    step(1);
    check_eq("mov_then_fetch_pc2", rom_addr, 32'h2);
    check_eq("mov_then_reg_en", 32'(reg_en), 32'h0);

    // SUB R5,R4,R5
    clear_rom();
    rom[0] = 32'h3545_0000;
    start();
    step(2);
    check_eq("sub_ex1_cs", 32'(cs), 32'd4);
    step(1);
    check_eq("sub_ex2_cs", 32'(cs), 32'd5);
    check_eq("sub_ex2_mode", 32'(add_sub_mode), 32'd0);
    check_eq("sub_ex2_out_en", 32'(adder_out_en), 32'd1);
    step(1);
    check_eq("sub_wb_reg_en", 32'(reg_en), 32'h0020);
    check_eq("sub_wb_mode", 32'(add_sub_mode), 32'd1);

    // STORE with slave_ready low for 3 BUS cycles
    clear_rom();
    rom[0] = 32'h4067_0000;
    start();
    step(2);
    check_eq("st_ex1_cs", 32'(cs), 32'd6);
    check_eq("st_ex1_addr_en", 32'(addr_en), 32'd1);
    step(1);
    check_eq("st_ex2_cs", 32'(cs), 32'd7);
    check_eq("st_ex2_wdata_bv", {wdata_en, bus_valid}, 32'b10);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("st_bus_wait", 32'(bus_valid), 32'd1);
    end
    step(1);
    check_eq("st_bus_last", 32'(bus_valid), 32'd1);
    slave_ready = 1'b1;
    step(1);
    slave_ready = 1'b0;
    check_eq("st_bus_drop", 32'(bus_valid), 32'd0);
    check_eq("st_fetch_pc1", rom_addr, 32'h1);

    // JMP, illegal opcode, HALT
    clear_rom();
    rom[0]     = 32'h5000_0010;
    rom[6'h10] = 32'h6000_0000;
    rom[6'h11] = 32'hF000_0000;
    start();
    step(2);
    check_eq("jmp_target", rom_addr, 32'h10);
    check_eq("jmp_no_illegal", 32'(illegal), 32'd0);
    step(2);
    check_eq("ill_as_nop_pc", rom_addr, 32'h11);
    check_eq("ill_flag", 32'(illegal), 32'd1);
    step(2);
    check_eq("halt_flag", 32'(halted), 32'd1);
    check_eq("halt_pc", rom_addr, 32'h12);
    step(4);
    check_eq("halt_frozen_pc", rom_addr, 32'h12);
    check_eq("halt_sticky", {halted, illegal}, 32'b11);

    // Reset during BUS handshake
    clear_rom();
    rom[0] = 32'h4067_0000;
    start();
    step(4);
    check_eq("rstbus_pre", 32'(bus_valid), 32'd1);
    rst_n = 1'b0;
    run   = 1'b0;
    step(1);
    check_eq("rstbus_bv", 32'(bus_valid), 32'd0);
    check_eq("rstbus_pc", rom_addr, 32'h0);
    check_eq("rstbus_halt_ill", {halted, illegal}, 32'h0);
    rst_n = 1'b1;
    step(3);
    check_eq("rstbus_idle", {31'h0, bus_valid} | rom_addr, 32'h0);

    // run dropped during ADD EX1
    clear_rom();
    rom[0] = 32'h2312_0000;
    start();
    step(2);
    run = 1'b0;
    check_eq("rundrop_ex1", 32'(adder_in_en), 32'd1);
    step(1);
    check_eq("rundrop_ex2", 32'(adder_out_en), 32'd1);
    step(1);
    check_eq("rundrop_wb", 32'(reg_en), 32'h0008);
    step(4);
    check_eq("rundrop_idle_pc", rom_addr, 32'h1);
    run = 1'b1;
    step(3);
    check_eq("rundrop_resume_pc", rom_addr, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
